ppm_symbol_serializer: RTL and testbench

//   Splits DATA_W-bit words from the byte source into SYM_W-bit PPM symbols.

---
 rtl/ppm_symbol_serializer.sv | 150 +++++++++++++++
 tb/tb_ppm_symbol_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_symbol_serializer.sv
// Splits DATA_W-bit words into SYM_W-bit PPM symbols held for SYM_CYCLES clocks each, with a one-word skid buffer.
// Optional macro PPM_SER_GRAY_EN: symbols are Gray-coded (s ^ (s >> 1)); otherwise plain binary.
module ppm_symbol_serializer #(
    parameter int DATA_W     = 8,
    parameter int SYM_W      = 2,
    parameter int SYM_CYCLES = 128,
    parameter int DONE_LEAD  = 3,
    parameter int MSB_FIRST  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SYM_W-1:0]  sym_out,
    output logic              sym_valid,
    output logic              sym_first,
    output logic              byte_done,
    output logic              busy
);
    localparam int NSYM  = DATA_W / SYM_W;
    localparam int CNT_W = $clog2(SYM_CYCLES);
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int NSLOT = 1 << IDX_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SYM_CYCLES - 1 - DONE_LEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] word_reg, word_next;
    logic [DATA_W-1:0] buf_reg, buf_next;
    logic              buf_full_reg, buf_full_next;
    logic [SYM_W-1:0]  sym_reg, sym_next;

    logic              accept;
    logic              sym_end;
    logic              word_end;
    logic [SYM_W-1:0]  slot [NSLOT];
    logic [SYM_W-1:0]  sym_raw;
    logic [SYM_W-1:0]  sym_code;

    assign in_ready = !buf_full_reg;
    assign accept   = in_valid && in_ready;
    assign sym_end  = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);
    assign word_end = sym_end && (idx_reg == IDX_LAST);

    // Slot table padded to a power of two so idx can index it directly.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NSYM) begin : g_used
                if (MSB_FIRST != 0) begin : g_msb
                    assign slot[gi] = word_next[DATA_W-1-gi*SYM_W -: SYM_W];
                end else begin : g_lsb
                    assign slot[gi] = word_next[gi*SYM_W +: SYM_W];
                end
            end else begin : g_pad
                assign slot[gi] = '0;
            end
        end
    endgenerate

    assign sym_raw = slot[idx_next];

`ifdef PPM_SER_GRAY_EN
    assign sym_code = sym_raw ^ (sym_raw >> 1);
`else
    assign sym_code = sym_raw;
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        word_next     = word_reg;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    word_next  = in_data;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (!sym_end) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    cnt_next = '0;
                    if (!word_end) begin
                        idx_next = idx_reg + 1'b1;
                    end else if (buf_full_reg) begin
                        word_next     = buf_reg;
                        buf_full_next = 1'b0;
                        idx_next      = '0;
                    end else if (in_valid) begin
                        word_next = in_data;
                        idx_next  = '0;
                    end else begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end
                end
                // A word offered exactly at end-of-word goes straight to the shift register instead.
                if (accept && !word_end) begin
                    buf_next      = in_data;
                    buf_full_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        sym_next = (state_next == SHIFT) ? sym_code : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            word_reg     <= '0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            sym_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            word_reg     <= word_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            sym_reg      <= sym_next;
        end
    end

    assign sym_out   = sym_reg;
    assign sym_valid = (state_reg == SHIFT);
    assign sym_first = (state_reg == SHIFT) && (cnt_reg == '0);
    assign byte_done = (state_reg == SHIFT) && (idx_reg == IDX_LAST) && (cnt_reg == CNT_DONE);
    assign busy      = (state_reg == SHIFT) || buf_full_reg;

endmodule

// File: tb/tb_ppm_symbol_serializer.sv
// Bench for ppm_symbol_serializer: three instances (LSB-first, MSB-first, one symbol per word), scoreboarded symbols.
module tb_ppm_symbol_serializer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] m_in_data = '0;
    logic       m_in_valid = 1'b0;
    logic       m_in_ready, m_sym_valid, m_sym_first, m_byte_done, m_busy;
    logic [1:0] m_sym_out;

    logic [7:0] b_in_data = '0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready, b_sym_valid, b_sym_first, b_byte_done, b_busy;
    logic [1:0] b_sym_out;

    logic [7:0] w_in_data = '0;
    logic       w_in_valid = 1'b0;
    logic       w_in_ready, w_sym_valid, w_sym_first, w_byte_done, w_busy;
    logic [7:0] w_sym_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_q[$];
    logic [7:0] b_q[$];
    logic [7:0] w_q[$];

    ppm_symbol_serializer #(.DATA_W(8), .SYM_W(2), .SYM_CYCLES(4), .DONE_LEAD(1), .MSB_FIRST(0)) u_main (
        .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .sym_out(m_sym_out), .sym_valid(m_sym_valid), .sym_first(m_sym_first),
        .byte_done(m_byte_done), .busy(m_busy));

    ppm_symbol_serializer #(.DATA_W(8), .SYM_W(2), .SYM_CYCLES(4), .DONE_LEAD(1), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sym_out(b_sym_out), .sym_valid(b_sym_valid), .sym_first(b_sym_first),
        .byte_done(b_byte_done), .busy(b_busy));

    ppm_symbol_serializer #(.DATA_W(8), .SYM_W(8), .SYM_CYCLES(4), .DONE_LEAD(1), .MSB_FIRST(0)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .sym_out(w_sym_out), .sym_valid(w_sym_valid), .sym_first(w_sym_first),
        .byte_done(w_byte_done), .busy(w_busy));

    function automatic logic [7:0] enc(input logic [7:0] s);
`ifdef PPM_SER_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected symbol stream for a word, in transmission order.
    task automatic push_word(input int sel, input logic [7:0] d);
        case (sel)
            0: for (int i = 0; i < 4; i++) m_q.push_back(enc((d >> (2 * i)) & 8'h03));
            1: for (int i = 0; i < 4; i++) b_q.push_back(enc((d >> (6 - 2 * i)) & 8'h03));
            default: w_q.push_back(enc(d));
        endcase
    endtask

    task automatic set_in(input int sel, input logic [7:0] d, input logic v);
        case (sel)
            0: begin m_in_data = d; m_in_valid = v; end
            1: begin b_in_data = d; b_in_valid = v; end
            default: begin w_in_data = d; w_in_valid = v; end
        endcase
    endtask

    function automatic logic ready_of(input int sel);
        case (sel)
            0: return m_in_ready;
            1: return b_in_ready;
            default: return w_in_ready;
        endcase
    endfunction

    // Offer a word; returns 1 ns after the accepting edge.
    task automatic send(input int sel, input logic [7:0] d, input bit keep);
        int waited = 0;
        set_in(sel, d, 1'b1);
        #1;
        while (!ready_of(sel) && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        assert (waited < 64) else begin
            errors++;
            $error("FAIL send_timeout observed=%0d cycles expected=<64", waited);
        end
        if (waited < 64) begin
            push_word(sel, d);
            @(posedge clk);
            #1;
        end
        if (!keep || waited >= 64) set_in(sel, d, 1'b0);
    endtask

    // k counts clocks after the first accepting edge; each word occupies 16 clocks.
    task automatic run_main(input int k0, input int k1, input int nwords, input int rdy_lo, input int rdy_hi);
        int total = 16 * nwords;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            chk($sformatf("m_sym_valid@%0d", k), m_sym_valid, k <= total);
            chk($sformatf("m_sym_first@%0d", k), m_sym_first, (k <= total) && ((k - 1) % 4 == 0));
            chk($sformatf("m_byte_done@%0d", k), m_byte_done, (k <= total) && (k % 16 == 15));
            chk($sformatf("m_in_ready@%0d", k), m_in_ready, !(k >= rdy_lo && k <= rdy_hi));
            chk($sformatf("m_busy@%0d", k), m_busy, (k <= total) || (k >= rdy_lo && k <= rdy_hi));
            if (k > total) chk($sformatf("m_idle_sym@%0d", k), m_sym_out, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_sym_first) begin
            checks++;
            assert (m_q.size() != 0) else begin
                errors++;
                $error("FAIL m_sym_extra observed=%0h expected=none", m_sym_out);
            end
            if (m_q.size() != 0) chk("m_sym", m_sym_out, m_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_sym_first) begin
            checks++;
            assert (b_q.size() != 0) else begin
                errors++;
                $error("FAIL b_sym_extra observed=%0h expected=none", b_sym_out);
            end
            if (b_q.size() != 0) chk("b_sym", b_sym_out, b_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && w_sym_first) begin
            checks++;
            assert (w_q.size() != 0) else begin
                errors++;
                $error("FAIL w_sym_extra observed=%0h expected=none", w_sym_out);
            end
            if (w_q.size() != 0) chk("w_sym", w_sym_out, w_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_sym_out", m_sym_out, 0);
        chk("rst_sym_valid", m_sym_valid, 0);
        chk("rst_sym_first", m_sym_first, 0);
        chk("rst_byte_done", m_byte_done, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_in_ready", m_in_ready, 1);
        chk("rst_w_sym_out", w_sym_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xB4, then idle
        send(0, 8'hB4, 1'b0);
        run_main(1, 17, 1, 1, 0);

        // Back-to-back 0xB4, 0x1B through the skid buffer
        @(negedge clk);
        send(0, 8'hB4, 1'b1);
        send(0, 8'h1B, 1'b0);
        run_main(2, 33, 2, 2, 16);

        // MSB-first order
        @(negedge clk);
        send(1, 8'hB4, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("b_byte_done@%0d", k), b_byte_done, k == 15);
            chk($sformatf("b_sym_valid@%0d", k), b_sym_valid, k <= 16);
        end
        chk("b_idle_sym", b_sym_out, 0);

        // One symbol per word, streamed
        @(negedge clk);
        send(2, 8'h5A, 1'b1);
        send(2, 8'hC3, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("w_sym_first@%0d", k), w_sym_first, k == 5);
            chk($sformatf("w_byte_done@%0d", k), w_byte_done, k == 3 || k == 7);
            chk($sformatf("w_sym_valid@%0d", k), w_sym_valid, k <= 8);
        end
        chk("w_idle_sym", w_sym_out, 0);

        // Asynchronous reset mid-word with the buffer full
        @(negedge clk);
        send(0, 8'hB4, 1'b1);
        send(0, 8'h1B, 1'b0);
        repeat (8) @(negedge clk);
        chk("abort_pre_in_ready", m_in_ready, 0);
        chk("abort_pre_first", m_sym_first, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_sym_out", m_sym_out, 0);
        chk("abort_sym_valid", m_sym_valid, 0);
        chk("abort_sym_first", m_sym_first, 0);
        chk("abort_byte_done", m_byte_done, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_in_ready", m_in_ready, 1);
        m_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("post_abort_valid@%0d", k), m_sym_valid, 0);
            chk($sformatf("post_abort_busy@%0d", k), m_busy, 0);
        end

        chk("m_q_drained", m_q.size(), 0);
        chk("b_q_drained", b_q.size(), 0);
        chk("w_q_drained", w_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
